// File: rtl/uart_reg_file.sv
// UART-accessed register file: framed burst reads/writes over a byte UART, read-only
// status mapping, address auto-increment and an inter-byte timeout for truncated frames.

module uart_rx #(
  parameter int CLKS_PER_BIT = 142
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       rx_in,
  output logic       rx_dv_out,
  output logic [7:0] rx_byte_out
);
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'((CLKS_PER_BIT - 1) / 2);

  rx_state_t     state_r, state_n_s;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    shift_r, byte_r;
  logic          meta_r, sync_r, dv_r, bit_end_s;

  assign bit_end_s   = (cnt_r == CNT_MAX);
  assign rx_dv_out   = dv_r;
  assign rx_byte_out = byte_r;

  // next-state: confirm start bit at its midpoint, then sample each bit centre
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      RX_IDLE:  if (!sync_r) state_n_s = RX_START; else state_n_s = RX_IDLE;
      RX_START: if (cnt_r == CNT_HALF) state_n_s = sync_r ? RX_IDLE : RX_DATA;
                else state_n_s = RX_START;
      RX_DATA:  if (bit_end_s && idx_r == 3'd7) state_n_s = RX_STOP; else state_n_s = RX_DATA;
      RX_STOP:  if (bit_end_s) state_n_s = RX_IDLE; else state_n_s = RX_STOP;
      default:  state_n_s = RX_IDLE;
    endcase
  end

  // synchroniser, bit timer and shift register
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_r <= RX_IDLE;
      cnt_r   <= {CW{1'b0}};
      idx_r   <= 3'd0;
      shift_r <= 8'h00;
      byte_r  <= 8'h00;
      meta_r  <= 1'b1;
      sync_r  <= 1'b1;
      dv_r    <= 1'b0;
    end else begin
      meta_r  <= rx_in;
      sync_r  <= meta_r;
      state_r <= state_n_s;
      cnt_r   <= (state_n_s != state_r || bit_end_s) ? {CW{1'b0}} : cnt_r + CW'(1);
      dv_r    <= (state_r == RX_STOP) && bit_end_s;
      if (state_r == RX_DATA && bit_end_s) begin
        shift_r <= {sync_r, shift_r[7:1]};
        idx_r   <= idx_r + 3'd1;
      end
      if (state_r == RX_STOP && bit_end_s) byte_r <= shift_r;
    end
  end
endmodule

module uart_tx #(
  parameter int CLKS_PER_BIT = 142
) (
  input  logic       clk_in,
  input  logic       rst_in_n,
  input  logic       tx_dv_in,
  input  logic [7:0] tx_byte_in,
  output logic       tx_active_out,
  output logic       tx_out,
  output logic       tx_done_out
);
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_MAX = CW'(CLKS_PER_BIT - 1);

  tx_state_t     state_r, state_n_s;
  logic [CW-1:0] cnt_r;
  logic [2:0]    idx_r;
  logic [7:0]    shift_r;
  logic          tx_r, done_r, active_r, bit_end_s;

  assign bit_end_s     = (cnt_r == CNT_MAX);
  assign tx_out        = tx_r;
  assign tx_done_out   = done_r;
  assign tx_active_out = active_r;

  // next-state for start / 8 data / stop bit sequencing
  always_comb begin
    state_n_s = state_r;
    case (state_r)
      TX_IDLE:  if (tx_dv_in) state_n_s = TX_START; else state_n_s = TX_IDLE;
      TX_START: if (bit_end_s) state_n_s = TX_DATA; else state_n_s = TX_START;
      TX_DATA:  if (bit_end_s && idx_r == 3'd7) state_n_s = TX_STOP; else state_n_s = TX_DATA;
      TX_STOP:  if (bit_end_s) state_n_s = TX_IDLE; else state_n_s = TX_STOP;
      default:  state_n_s = TX_IDLE;
    endcase
  end

  // serial line is registered and forced idle-high by reset
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_r  <= TX_IDLE;
      cnt_r    <= {CW{1'b0}};
      idx_r    <= 3'd0;
      shift_r  <= 8'h00;
      tx_r     <= 1'b1;
      done_r   <= 1'b0;
      active_r <= 1'b0;
    end else begin
      state_r  <= state_n_s;
      cnt_r    <= (state_r == TX_IDLE || bit_end_s) ? {CW{1'b0}} : cnt_r + CW'(1);
      done_r   <= (state_r == TX_STOP) && bit_end_s;
      active_r <= (state_n_s != TX_IDLE);
      if (state_r == TX_IDLE && tx_dv_in) begin
        shift_r <= tx_byte_in;
        tx_r    <= 1'b0;
      end else if (state_r == TX_START && bit_end_s) begin
        tx_r <= shift_r[0];
      end else if (state_r == TX_DATA && bit_end_s) begin
        tx_r    <= (idx_r == 3'd7) ? 1'b1 : shift_r[1];
        shift_r <= {1'b0, shift_r[7:1]};
        idx_r   <= idx_r + 3'd1;
      end
    end
  end
endmodule

module uart_reg_file #(
  parameter int                  CLKS_PER_BIT = 142,
  parameter int                  N_REGS       = 16,
  parameter logic [N_REGS-1:0]   RO_MASK      = 16'h0002,
  parameter logic [N_REGS*8-1:0] RST_VALS     = {{(N_REGS*8-8){1'b0}}, 8'h06},
  parameter int                  TIMEOUT_CLKS = 10 * CLKS_PER_BIT * 4
) (
  input  logic                clk_in,
  input  logic                rst_in_n,
  input  logic                rx_in,
  input  logic [N_REGS*8-1:0] status_in,
  output logic                tx_out,
  output logic [N_REGS*8-1:0] regs_out,
  output logic [N_REGS-1:0]   wr_strobe_out,
  output logic                busy_out,
  output logic                err_out
);
  typedef enum logic [2:0] {ST_IDLE, ST_LEN, ST_WDATA, ST_RD_LOAD, ST_RD_WAIT} state_t;
  localparam int TO_W = $clog2(TIMEOUT_CLKS);
  localparam logic [TO_W-1:0] TO_LIMIT  = TO_W'(TIMEOUT_CLKS - 1);
  localparam logic [7:0]      N_REGS_W  = 8'(N_REGS);
  localparam logic [6:0]      LAST_ADDR = 7'(N_REGS - 1);

  state_t              state_r, state_n_s;
  logic [6:0]          addr_r, addr_inc_s;
  logic [8:0]          count_r;
  logic                rw_r, busy_r, err_r, in_range_s, to_hit_s;
  logic [TO_W-1:0]     to_cnt_r;
  logic [N_REGS*8-1:0] regs_r;
  logic [N_REGS-1:0]   wr_strobe_r;
  logic [7:0]          rx_byte_s, rd_byte_s;
  logic                rx_dv_s, tx_dv_s, tx_done_s, tx_active_s;

  uart_rx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_rx (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .rx_in(rx_in),
    .rx_dv_out(rx_dv_s), .rx_byte_out(rx_byte_s)
  );

  uart_tx #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tx (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .tx_dv_in(tx_dv_s), .tx_byte_in(rd_byte_s),
    .tx_active_out(tx_active_s), .tx_out(tx_out), .tx_done_out(tx_done_s)
  );

  assign regs_out      = regs_r;
  assign wr_strobe_out = wr_strobe_r;
  assign busy_out      = busy_r;
  assign err_out       = err_r;
  assign tx_dv_s       = (state_r == ST_RD_LOAD) && !tx_active_s;

  // address increment, read mux and frame sequencing
  always_comb begin
    in_range_s = ({1'b0, addr_r} < N_REGS_W);
    if (in_range_s && addr_r == LAST_ADDR) addr_inc_s = 7'd0;
    else addr_inc_s = addr_r + 7'd1;
    rd_byte_s = 8'hBA;
    for (int i = 0; i < N_REGS; i++) begin
      rd_byte_s = (addr_r == 7'(i)) ? (RO_MASK[i] ? status_in[i*8 +: 8] : regs_r[i*8 +: 8])
                                    : rd_byte_s;
    end
    to_hit_s  = (to_cnt_r == TO_LIMIT);
    state_n_s = state_r;
    case (state_r)
      ST_IDLE:    if (rx_dv_s) state_n_s = ST_LEN; else state_n_s = ST_IDLE;
      ST_LEN:     if (rx_dv_s) state_n_s = rw_r ? ST_RD_LOAD : ST_WDATA;
                  else if (to_hit_s) state_n_s = ST_IDLE;
                  else state_n_s = ST_LEN;
      ST_WDATA:   if (rx_dv_s) state_n_s = (count_r == 9'd1) ? ST_IDLE : ST_WDATA;
                  else if (to_hit_s) state_n_s = ST_IDLE;
                  else state_n_s = ST_WDATA;
      ST_RD_LOAD: if (!tx_active_s) state_n_s = ST_RD_WAIT; else state_n_s = ST_RD_LOAD;
      ST_RD_WAIT: if (tx_done_s) state_n_s = (count_r == 9'd1) ? ST_IDLE : ST_RD_LOAD;
                  else state_n_s = ST_RD_WAIT;
      default:    state_n_s = ST_IDLE;
    endcase
  end

  // frame datapath: the received byte beats a coincident timeout
  always_ff @(posedge clk_in or negedge rst_in_n) begin
    if (!rst_in_n) begin
      state_r     <= ST_IDLE;
      addr_r      <= 7'd0;
      count_r     <= 9'd0;
      rw_r        <= 1'b0;
      to_cnt_r    <= {TO_W{1'b0}};
      busy_r      <= 1'b0;
      err_r       <= 1'b0;
      wr_strobe_r <= {N_REGS{1'b0}};
      for (int i = 0; i < N_REGS; i++) begin
        regs_r[i*8 +: 8] <= RO_MASK[i] ? 8'h00 : RST_VALS[i*8 +: 8];
      end
    end else begin
      state_r     <= state_n_s;
      busy_r      <= (state_n_s != ST_IDLE);
      wr_strobe_r <= {N_REGS{1'b0}};
      if ((state_r == ST_LEN || state_r == ST_WDATA) && !rx_dv_s && !to_hit_s)
        to_cnt_r <= to_cnt_r + TO_W'(1);
      else
        to_cnt_r <= {TO_W{1'b0}};
      case (state_r)
        ST_IDLE: if (rx_dv_s) begin
          addr_r <= rx_byte_s[6:0];
          rw_r   <= rx_byte_s[7];
          if (rx_byte_s == 8'h7F) err_r <= 1'b0;
        end
        ST_LEN: if (rx_dv_s) count_r <= {1'b0, rx_byte_s} + 9'd1;
                else if (to_hit_s) err_r <= 1'b1;
        ST_WDATA: if (rx_dv_s) begin
          for (int i = 0; i < N_REGS; i++) begin
            if (addr_r == 7'(i) && !RO_MASK[i]) begin
              regs_r[i*8 +: 8] <= rx_byte_s;
              wr_strobe_r[i]   <= 1'b1;
            end
          end
          addr_r  <= addr_inc_s;
          count_r <= count_r - 9'd1;
        end else if (to_hit_s) err_r <= 1'b1;
        ST_RD_WAIT: if (tx_done_s) begin
          addr_r  <= addr_inc_s;
          count_r <= count_r - 9'd1;
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_reg_file.sv
// Bench for uart_reg_file: host frames driven serially, tx bytes decoded and scored
// against a queue of expected bytes built from a register model.

module tb_uart_reg_file;
  localparam int CLKS = 16;
  localparam int NR   = 16;
  localparam int TO   = 10 * CLKS * 4;
  localparam logic [NR*8-1:0] RST_EXP = 128'h06;

  logic            clk_in = 1'b0;
  logic            rst_in_n = 1'b0;
  logic            rx_in = 1'b1;
  logic [NR*8-1:0] status_in;
  logic            tx_out, busy_out, err_out;
  logic [NR*8-1:0] regs_out;
  logic [NR-1:0]   wr_strobe_out;

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] exp_q[$];
  logic [7:0] exp_regs[NR];
  int         strobe_cnt[NR];
  logic [7:0] strobe_val[NR];
  logic [7:0] mon_got, mon_exp;
  bit         mon_abort;

  uart_reg_file #(.CLKS_PER_BIT(CLKS), .N_REGS(NR)) dut (
    .clk_in(clk_in), .rst_in_n(rst_in_n), .rx_in(rx_in), .status_in(status_in),
    .tx_out(tx_out), .regs_out(regs_out), .wr_strobe_out(wr_strobe_out),
    .busy_out(busy_out), .err_out(err_out)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // tx decoder: each completed byte is scored against the expected queue
  always begin
    @(negedge clk_in);
    if (rst_in_n && tx_out === 1'b0) begin
      mon_abort = 1'b0;
      repeat (CLKS / 2) begin @(negedge clk_in); if (!rst_in_n) mon_abort = 1'b1; end
      for (int k = 0; k < 8; k++) begin
        repeat (CLKS) begin @(negedge clk_in); if (!rst_in_n) mon_abort = 1'b1; end
        mon_got[k] = tx_out;
      end
      repeat (CLKS) begin @(negedge clk_in); if (!rst_in_n) mon_abort = 1'b1; end
      if (!mon_abort) begin
        n_tests++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL tx_unexpected: got %02h, no byte expected", mon_got);
        end else begin
          mon_exp = exp_q.pop_front();
          if (mon_got !== mon_exp) begin
            n_fail++;
            $display("FAIL tx_byte: got %02h, expected %02h", mon_got, mon_exp);
          end
        end
      end
    end
  end

  // strobe monitor: width and the register value visible while strobed
  always @(negedge clk_in) begin
    for (int i = 0; i < NR; i++) begin
      if (wr_strobe_out[i]) begin
        strobe_cnt[i]++;
        strobe_val[i] = regs_out[i*8 +: 8];
      end
    end
  end

  function automatic logic [NR*8-1:0] model_flat();
    logic [NR*8-1:0] f;
    for (int i = 0; i < NR; i++) f[i*8 +: 8] = exp_regs[i];
    return f;
  endfunction

  task automatic send_byte(input logic [7:0] b);
    rx_in = 1'b0;
    repeat (CLKS) @(negedge clk_in);
    for (int i = 0; i < 8; i++) begin
      rx_in = b[i];
      repeat (CLKS) @(negedge clk_in);
    end
    rx_in = 1'b1;
    repeat (CLKS) @(negedge clk_in);
  endtask

  task automatic drain();
    for (int c = 0; c < 20 * CLKS * 12; c++) begin
      @(negedge clk_in);
      if (exp_q.size() == 0 && busy_out == 1'b0) break;
    end
    repeat (3) @(negedge clk_in);
  endtask

  task automatic clear_strobes();
    for (int i = 0; i < NR; i++) begin strobe_cnt[i] = 0; strobe_val[i] = 8'h00; end
  endtask

  task automatic reset_model();
    for (int i = 0; i < NR; i++) exp_regs[i] = RST_EXP[i*8 +: 8];
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk_in);
    n_tests++; if (tx_out !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b, expected 1", tx_out); end
    rst_in_n = 1'b1;
    repeat (3) @(negedge clk_in);
    n_tests++; if (regs_out !== RST_EXP) begin n_fail++; $display("FAIL rst_regs: got %h, expected %h", regs_out, RST_EXP); end
    n_tests++; if ({busy_out, err_out, wr_strobe_out} !== 18'd0) begin n_fail++; $display("FAIL rst_flags: busy %b err %b strobe %h", busy_out, err_out, wr_strobe_out); end
  endtask

  task automatic test_read_addr0();
    exp_q.push_back(8'h06);
    send_byte(8'h80);
    n_tests++; if (busy_out !== 1'b1) begin n_fail++; $display("FAIL busy_after_cmd: got %b, expected 1", busy_out); end
    send_byte(8'h00);
    drain();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL read0_pending: %0d bytes not sent", exp_q.size()); end
    n_tests++; if ({busy_out, err_out} !== 2'b00) begin n_fail++; $display("FAIL read0_flags: busy %b err %b, expected 0 0", busy_out, err_out); end
  endtask

  task automatic test_burst_write();
    logic [7:0] exp_cnt;
    clear_strobes();
    send_byte(8'h0E); send_byte(8'h04);
    send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4); send_byte(8'hA5);
    exp_regs[14] = 8'hA1; exp_regs[15] = 8'hA2; exp_regs[0] = 8'hA3; exp_regs[2] = 8'hA5;
    repeat (3) @(negedge clk_in);
    n_tests++; if (regs_out !== model_flat()) begin n_fail++; $display("FAIL burst_regs: got %h, expected %h", regs_out, model_flat()); end
    for (int i = 0; i < NR; i++) begin
      exp_cnt = (i == 14 || i == 15 || i == 0 || i == 2) ? 8'd1 : 8'd0;
      n_tests++; if (strobe_cnt[i] != int'(exp_cnt)) begin n_fail++; $display("FAIL burst_strobe_cnt[%0d]: got %0d, expected %0d", i, strobe_cnt[i], exp_cnt); end
      if (exp_cnt == 8'd1) begin
        n_tests++; if (strobe_val[i] !== exp_regs[i]) begin n_fail++; $display("FAIL burst_strobe_val[%0d]: got %02h, expected %02h", i, strobe_val[i], exp_regs[i]); end
      end
    end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL burst_busy: got %b, expected 0", busy_out); end
  endtask

  task automatic test_ro_read();
    status_in[15:8] = 8'h5C;
    exp_q.push_back(8'h5C);
    exp_q.push_back(exp_regs[2]);
    send_byte(8'h81); send_byte(8'h01);
    drain();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL ro_pending: %0d bytes not sent", exp_q.size()); end
    n_tests++; if (regs_out[15:8] !== 8'h00) begin n_fail++; $display("FAIL ro_slot: got %02h, expected 00", regs_out[15:8]); end
  endtask

  task automatic test_out_of_range();
    exp_q.push_back(8'hBA);
    send_byte(8'hA0); send_byte(8'h00);
    drain();
    exp_q.push_back(8'hBA);
    exp_q.push_back(exp_regs[0]);
    send_byte(8'hFF); send_byte(8'h01);
    drain();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL oor_pending: %0d bytes not sent", exp_q.size()); end
    clear_strobes();
    send_byte(8'h20); send_byte(8'h00); send_byte(8'h77);
    repeat (3) @(negedge clk_in);
    n_tests++; if (regs_out !== model_flat()) begin n_fail++; $display("FAIL oor_regs: got %h, expected %h", regs_out, model_flat()); end
    n_tests++; if (strobe_cnt.sum() != 0) begin n_fail++; $display("FAIL oor_strobe: got %0d pulses, expected 0", strobe_cnt.sum()); end
  endtask

  task automatic test_timeout();
    send_byte(8'h07); send_byte(8'h00);
    repeat (TO - 240) @(negedge clk_in);
    send_byte(8'h33);
    exp_regs[7] = 8'h33;
    repeat (3) @(negedge clk_in);
    n_tests++; if (regs_out[63:56] !== 8'h33 || err_out !== 1'b0) begin n_fail++; $display("FAIL slow_frame: reg7 %02h err %b, expected 33 0", regs_out[63:56], err_out); end
    send_byte(8'h05); send_byte(8'h01); send_byte(8'h11);
    exp_regs[5] = 8'h11;
    repeat (TO + 60) @(negedge clk_in);
    n_tests++; if (regs_out !== model_flat()) begin n_fail++; $display("FAIL timeout_regs: got %h, expected %h", regs_out, model_flat()); end
    n_tests++; if ({busy_out, err_out} !== 2'b01) begin n_fail++; $display("FAIL timeout_flags: busy %b err %b, expected 0 1", busy_out, err_out); end
    send_byte(8'h7F);
    n_tests++; if (err_out !== 1'b0) begin n_fail++; $display("FAIL err_clear: got %b, expected 0", err_out); end
    send_byte(8'h00); send_byte(8'h00);
    repeat (3) @(negedge clk_in);
    n_tests++; if (regs_out !== model_flat() || busy_out !== 1'b0) begin n_fail++; $display("FAIL clear_frame: regs %h busy %b, expected %h 0", regs_out, busy_out, model_flat()); end
  endtask

  task automatic test_reset_mid();
    for (int a = 0; a < NR; a++) exp_q.push_back((a == 1) ? 8'h5C : exp_regs[a]);
    send_byte(8'h80); send_byte(8'h0F);
    repeat (250) @(negedge clk_in);
    rst_in_n = 1'b0;
    exp_q.delete();
    reset_model();
    #1;
    n_tests++; if (tx_out !== 1'b1) begin n_fail++; $display("FAIL midrst_tx: got %b, expected 1", tx_out); end
    n_tests++; if (regs_out !== RST_EXP) begin n_fail++; $display("FAIL midrst_regs: got %h, expected %h", regs_out, RST_EXP); end
    n_tests++; if (busy_out !== 1'b0) begin n_fail++; $display("FAIL midrst_busy: got %b, expected 0", busy_out); end
    repeat (3) @(negedge clk_in);
    rst_in_n = 1'b1;
    repeat (3) @(negedge clk_in);
    exp_q.push_back(8'h06);
    send_byte(8'h80); send_byte(8'h00);
    drain();
    n_tests++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL postrst_pending: %0d bytes not sent", exp_q.size()); end
  endtask

  initial begin
    status_in = {NR{8'hEE}};
    reset_model();
    clear_strobes();
    test_reset();
    test_read_addr0();
    test_burst_write();
    test_ro_read();
    test_out_of_range();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
